alu_top: RTL and testbench

ALU_TOP -- requirements
Module: alu_top

---
 rtl/alu_top.sv | 152 +++++++++++++++
 tb/tb_alu_top.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_top.sv
// alu_top: 32-bit multi-cycle ALU with an IDLE -> EXEC -> DONE handshake.
// Operands and opcode are captured in IDLE. The result and flags are registered
// when EXEC exits. ALU_ready pulses for the single DONE cycle, and the result
// holds until the next one is registered.
module alu_top (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic [31:0] ALU_dat1,
    input  logic [31:0] ALU_dat2,
    input  logic [5:0]  Instruction_from_CU,
    output logic [31:0] ALU_out,
    output logic        ALU_zero,
    output logic        ALU_overflow,
    output logic        ALU_con_met,
    output logic        ALU_err,
    output logic        ALU_ready,
    output logic        ALU_accept
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BLT  = 6'd6;
    localparam logic [5:0] OP_BGE  = 6'd7;
    localparam logic [5:0] OP_BLTU = 6'd8;
    localparam logic [5:0] OP_BGEU = 6'd9;
    localparam logic [5:0] OP_ADD  = 6'd27;
    localparam logic [5:0] OP_SUB  = 6'd28;
    localparam logic [5:0] OP_SLL  = 6'd29;
    localparam logic [5:0] OP_SLT  = 6'd30;
    localparam logic [5:0] OP_SLTU = 6'd31;
    localparam logic [5:0] OP_XOR  = 6'd32;
    localparam logic [5:0] OP_SRL  = 6'd33;
    localparam logic [5:0] OP_SRA  = 6'd34;
    localparam logic [5:0] OP_OR   = 6'd35;
    localparam logic [5:0] OP_AND  = 6'd36;

    logic [1:0]  state_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [5:0]  op_r;
    logic        ready_r;

    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic [4:0]  shamt_s;
    logic        lt_s;
    logic        ltu_s;
    logic [31:0] res_s;
    logic        ovf_s;
    logic        con_s;
    logic        err_s;

    assign ALU_accept = (state_r == ST_IDLE) && !reset;
    assign ALU_ready  = ready_r;

    // Result and flag datapath evaluated from the captured operands.
    always_comb begin
        sum_s   = a_r + b_r;
        diff_s  = a_r - b_r;
        shamt_s = b_r[4:0];
        lt_s    = $signed(a_r) < $signed(b_r);
        ltu_s   = a_r < b_r;
        res_s   = 32'd0;
        ovf_s   = 1'b0;
        con_s   = 1'b0;
        err_s   = 1'b0;
        case (op_r)
            OP_ADD: begin
                res_s = sum_s;
                ovf_s = (a_r[31] == b_r[31]) && (sum_s[31] != a_r[31]);
            end
            OP_SUB: begin
                res_s = diff_s;
                ovf_s = (a_r[31] != b_r[31]) && (diff_s[31] != a_r[31]);
            end
            OP_SLL:  res_s = a_r << shamt_s;
            OP_SLT:  res_s = {31'd0, lt_s};
            OP_SLTU: res_s = {31'd0, ltu_s};
            OP_XOR:  res_s = a_r ^ b_r;
            OP_SRL:  res_s = a_r >> shamt_s;
            OP_SRA:  res_s = $signed(a_r) >>> shamt_s;
            OP_OR:   res_s = a_r | b_r;
            OP_AND:  res_s = a_r & b_r;
            OP_BEQ:  con_s = (a_r == b_r);
            OP_BNE:  con_s = (a_r != b_r);
            OP_BLT:  con_s = lt_s;
            OP_BGE:  con_s = !lt_s;
            OP_BLTU: con_s = ltu_s;
            OP_BGEU: con_s = !ltu_s;
            default: err_s = 1'b1;
        endcase
    end

    // Handshake state machine with operand capture in IDLE.
    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            op_r    <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Instruction_from_CU != OP_NOP) begin
                        a_r     <= ALU_dat1;
                        b_r     <= ALU_dat2;
                        op_r    <= Instruction_from_CU;
                        state_r <= ST_EXEC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: state_r <= ST_DONE;
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Result and flag registers load on EXEC exit and otherwise hold.
    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            ALU_out      <= 32'd0;
            ALU_zero     <= 1'b0;
            ALU_overflow <= 1'b0;
            ALU_con_met  <= 1'b0;
            ALU_err      <= 1'b0;
            ready_r      <= 1'b0;
        end else begin
            ready_r <= (state_r == ST_EXEC);
            if (state_r == ST_EXEC) begin
                ALU_out      <= res_s;
                ALU_zero     <= (res_s == 32'd0);
                ALU_overflow <= ovf_s;
                ALU_con_met  <= con_s;
                ALU_err      <= err_s;
            end else begin
                ALU_out      <= ALU_out;
                ALU_zero     <= ALU_zero;
                ALU_overflow <= ALU_overflow;
                ALU_con_met  <= ALU_con_met;
                ALU_err      <= ALU_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: directed and randomized checks of alu_top against a behavioural model.
module tb_alu_top;

    logic        soc_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] ALU_dat1 = 32'd0;
    logic [31:0] ALU_dat2 = 32'd0;
    logic [5:0]  Instruction_from_CU = 6'd0;
    logic [31:0] ALU_out;
    logic        ALU_zero, ALU_overflow, ALU_con_met, ALU_err, ALU_ready, ALU_accept;

    int checks = 0;
    int errors = 0;

    alu_top dut (
        .soc_clk(soc_clk), .reset(reset),
        .ALU_dat1(ALU_dat1), .ALU_dat2(ALU_dat2),
        .Instruction_from_CU(Instruction_from_CU),
        .ALU_out(ALU_out), .ALU_zero(ALU_zero), .ALU_overflow(ALU_overflow),
        .ALU_con_met(ALU_con_met), .ALU_err(ALU_err),
        .ALU_ready(ALU_ready), .ALU_accept(ALU_accept)
    );

    always #5 soc_clk = ~soc_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model written from the opcode rules using wide signed arithmetic.
    function automatic void ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] o, output logic ovf,
                                    output logic con, output logic err);
        longint sa, sb, wide;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        o = 32'd0; ovf = 1'b0; con = 1'b0; err = 1'b0;
        case (op)
            6'd27: begin wide = sa + sb; o = a + b; ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            6'd28: begin wide = sa - sb; o = a - b; ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            6'd29: o = a << sh;
            6'd30: o = (sa < sb) ? 32'd1 : 32'd0;
            6'd31: o = (a < b) ? 32'd1 : 32'd0;
            6'd32: o = a ^ b;
            6'd33: o = a >> sh;
            6'd34: o = 32'(sa >>> sh);
            6'd35: o = a | b;
            6'd36: o = a & b;
            6'd4:  con = (a == b);
            6'd5:  con = (a != b);
            6'd6:  con = (sa < sb);
            6'd7:  con = (sa >= sb);
            6'd8:  con = (a < b);
            6'd9:  con = (a >= b);
            default: err = 1'b1;
        endcase
    endfunction

    // Full handshake for one operation, with inputs scrambled while busy.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eo;
        logic eovf, econ, eerr;
        int waited;
        ref_alu(op, a, b, eo, eovf, econ, eerr);
        waited = 0;
        @(negedge soc_clk);
        while (!ALU_accept && waited < 10) begin
            @(negedge soc_clk);
            waited++;
        end
        chk({tag, "_accept_before"}, {31'd0, ALU_accept}, 32'd1);
        ALU_dat1 = a; ALU_dat2 = b; Instruction_from_CU = op;
        @(posedge soc_clk); #1;
        chk({tag, "_accept_exec"}, {31'd0, ALU_accept}, 32'd0);
        chk({tag, "_ready_exec"}, {31'd0, ALU_ready}, 32'd0);
        ALU_dat1 = $urandom; ALU_dat2 = $urandom; Instruction_from_CU = 6'($urandom_range(1, 63));
        @(posedge soc_clk); #1;
        chk({tag, "_ready"}, {31'd0, ALU_ready}, 32'd1);
        chk({tag, "_out"}, ALU_out, eo);
        chk({tag, "_zero"}, {31'd0, ALU_zero}, {31'd0, eo == 32'd0});
        chk({tag, "_ovf"}, {31'd0, ALU_overflow}, {31'd0, eovf});
        chk({tag, "_con"}, {31'd0, ALU_con_met}, {31'd0, econ});
        chk({tag, "_err"}, {31'd0, ALU_err}, {31'd0, eerr});
        Instruction_from_CU = 6'd0;
        @(posedge soc_clk); #1;
        chk({tag, "_ready_drop"}, {31'd0, ALU_ready}, 32'd0);
        chk({tag, "_accept_back"}, {31'd0, ALU_accept}, 32'd1);
        chk({tag, "_out_hold"}, ALU_out, eo);
    endtask

    logic [5:0] listed [16] = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd27, 6'd28,
                                6'd29, 6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36};

    initial begin
        logic [5:0]  rop;
        logic [31:0] ra, rb;

        // Reset state
        repeat (2) @(posedge soc_clk);
        #1;
        chk("rst_out", ALU_out, 32'd0);
        chk("rst_flags", {27'd0, ALU_zero, ALU_overflow, ALU_con_met, ALU_err, ALU_ready}, 32'd0);
        chk("rst_accept", {31'd0, ALU_accept}, 32'd0);
        @(negedge soc_clk);
        reset = 1'b0;
        #1;
        chk("rel_accept", {31'd0, ALU_accept}, 32'd1);

        // Directed arithmetic, shifts, logic and compares
        run_op("add", 6'd27, 32'd10, 32'd5);
        run_op("sub", 6'd28, 32'd5, 32'd10);
        run_op("sll", 6'd29, 32'd1, 32'd2);
        run_op("srl", 6'd33, 32'd8, 32'd2);
        run_op("sra", 6'd34, 32'hFFFFFFF8, 32'd2);
        run_op("and", 6'd36, 32'hF0, 32'h0F);
        run_op("xor", 6'd32, 32'hF0, 32'h0F);
        run_op("or",  6'd35, 32'hF0, 32'h0F);
        run_op("slt", 6'd30, 32'hFFFFFFFF, 32'd10);
        run_op("sltu", 6'd31, 32'hFFFFFFFF, 32'd10);
        chk("sltu_lit_zero", {31'd0, ALU_zero}, 32'd1);

        // Branches and their inverses
        run_op("beq", 6'd4, 32'd5, 32'd5);
        chk("beq_lit_con", {31'd0, ALU_con_met}, 32'd1);
        run_op("beq_n", 6'd4, 32'd5, 32'd4);
        run_op("bne", 6'd5, 32'd5, 32'd4);
        run_op("bne_n", 6'd5, 32'd5, 32'd5);
        run_op("blt", 6'd6, 32'hFFFFFFFB, 32'd5);
        run_op("blt_n", 6'd6, 32'd5, 32'hFFFFFFFB);
        run_op("bge", 6'd7, 32'd5, 32'hFFFFFFFB);
        run_op("bge_n", 6'd7, 32'hFFFFFFFB, 32'd5);
        run_op("bltu", 6'd8, 32'd10, 32'd20);
        run_op("bltu_n", 6'd8, 32'd20, 32'd10);
        run_op("bgeu", 6'd9, 32'd20, 32'd10);
        run_op("bgeu_n", 6'd9, 32'd10, 32'd20);

        // Boundaries
        run_op("add_ovf", 6'd27, 32'h7FFFFFFF, 32'd1);
        chk("add_ovf_lit", {ALU_overflow, ALU_out[30:0]}, 32'h80000000);
        run_op("sub_ovf", 6'd28, 32'h80000000, 32'd1);
        chk("sub_ovf_lit", {31'd0, ALU_overflow}, 32'd1);
        run_op("err63", 6'd63, 32'd123, 32'd456);
        chk("err63_lit", {31'd0, ALU_err}, 32'd1);

        // NOP held in IDLE never produces a result
        Instruction_from_CU = 6'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge soc_clk); #1;
            chk("nop_ready", {31'd0, ALU_ready}, 32'd0);
            chk("nop_accept", {31'd0, ALU_accept}, 32'd1);
        end

        // Reset during EXEC aborts without a ready pulse
        @(negedge soc_clk);
        ALU_dat1 = 32'd1; ALU_dat2 = 32'd2; Instruction_from_CU = 6'd27;
        @(posedge soc_clk); #1;
        Instruction_from_CU = 6'd0;
        reset = 1'b1;
        #1;
        chk("abort_accept", {31'd0, ALU_accept}, 32'd0);
        chk("abort_out", ALU_out, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge soc_clk); #1;
            chk("abort_ready", {31'd0, ALU_ready}, 32'd0);
        end
        @(negedge soc_clk);
        reset = 1'b0;
        #1;
        chk("abort_accept_rel", {31'd0, ALU_accept}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge soc_clk); #1;
            chk("abort_no_ready", {31'd0, ALU_ready}, 32'd0);
        end

        // Randomized operations
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) rop = 6'($urandom_range(1, 63));
            else rop = listed[$urandom_range(0, 15)];
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
            if ($urandom_range(0, 3) == 0) rb = {ra[31], 31'($urandom)};
            run_op("rand", rop, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
